rr_mux4_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4-input, 16-bit registered selector. Four requesters present single-beat 16-bit words with a request/grant handshake. The block chooses one requester per accepted beat and registers its word onto a single valid/ready output stream. A bounded-burst rule lets the current winner keep the path for consecutive beats without starving the other requesters.

---
 rtl/rr_arb_pkg.sv | 26 ++
 rtl/mux4_reg16.sv | 38 +++
 rtl/rr_mux4_arbiter.sv | 94 +++++++++
 tb/tb_rr_mux4_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared widths, state type and rotate-priority helper for rr_mux4_arbiter
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // First set request bit at or after index start, wrapping modulo NUM_REQ.
  // Scans from the farthest offset back to the nearest so the nearest hit wins.
  // Returns start when nothing is set; callers only use it when some bit is set.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   start);
    logic [SEL_W-1:0] idx;
    rr_pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4_reg16.sv
// rtl/mux4_reg16.sv - enable-gated registered 4:1 selector with async active-low reset
module mux4_reg16
  import rr_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] pick;

  // Select the candidate word for the next load.
  always_comb begin
    pick = d0;
    case (sel)
      2'd0:    pick = d0;
      2'd1:    pick = d1;
      2'd2:    pick = d2;
      default: pick = d3;
    endcase
  end

  // Load only on accept; otherwise the held word stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= pick;
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin arbiter with bounded bursts feeding a registered 4:1 stream
module rr_mux4_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [DATA_W-1:0]  i_data_0,
  input  logic [DATA_W-1:0]  i_data_1,
  input  logic [DATA_W-1:0]  i_data_2,
  input  logic [DATA_W-1:0]  i_data_3,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  output logic [SEL_W-1:0]   o_sel,
  input  logic               i_ready
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   last, last_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   rr_start;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] gnt;
  logic               slot_free;
  logic               accept;

  // Pick the winner and next burst state; the previous winner keeps the path
  // while under its burst budget, or indefinitely when nobody else is asking.
  always_comb begin
    slot_free = !o_valid || i_ready;
    accept    = slot_free && (|i_req);
    rr_start  = last + SEL_W'(1);
    others    = i_req & ~(NUM_REQ'(1) << last);
    win       = rr_pick(i_req, rr_start);
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    gnt       = '0;
    if (slot_free) begin
      if (accept) begin
        state_nxt = BURST;
        cnt_nxt   = 4'd1;
        if ((state == BURST) && i_req[last] && ((cnt < MAX_CNT) || (others == '0))) begin
          win     = last;
          cnt_nxt = (cnt < MAX_CNT) ? 4'(cnt + 4'd1) : cnt;
        end
        last_nxt = win;
        gnt      = NUM_REQ'(1) << win;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  // No grant may escape while reset is held, even though gnt is combinational.
  assign o_gnt = i_rst_n ? gnt : '0;

  // Arbitration state and output stream flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= SEL_W'(NUM_REQ - 1);
      o_valid <= 1'b0;
      o_sel   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      if (slot_free) o_valid <= |i_req;
      if (accept)    o_sel   <= win;
    end
  end

  mux4_reg16 u_mux (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (accept),
    .sel   (win),
    .d0    (i_data_0),
    .d1    (i_data_1),
    .d2    (i_data_2),
    .d3    (i_data_3),
    .q     (o_data)
  );

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb/tb_rr_mux4_arbiter.sv - scoreboard bench for rr_mux4_arbiter
module tb_rr_mux4_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req1;
  logic        ready, ready1;
  logic [15:0] d [4];
  logic [3:0]  gnt, gnt1;
  logic        valid, valid1;
  logic [15:0] data, data1;
  logic [1:0]  sel, sel1;

  logic [3:0]  gq0 [$];
  logic [17:0] bq0 [$];
  logic [3:0]  gq1 [$];
  logic [17:0] bq1 [$];

  int total = 0;
  int bad   = 0;

  logic        chk_zero, chk_hold, chk_idle, chk_end, done;
  logic [15:0] hold_val;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.MAX_BURST(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_data_0(d[0]), .i_data_1(d[1]), .i_data_2(d[2]), .i_data_3(d[3]),
    .o_gnt(gnt), .o_valid(valid), .o_data(data), .o_sel(sel), .i_ready(ready)
  );

  rr_mux4_arbiter #(.MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1),
    .i_data_0(d[0]), .i_data_1(d[1]), .i_data_2(d[2]), .i_data_3(d[3]),
    .o_gnt(gnt1), .o_valid(valid1), .o_data(data1), .o_sel(sel1), .i_ready(ready1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push0(input int w);
    gq0.push_back(4'(1 << w));
    bq0.push_back({2'(w), d[w]});
  endtask

  task automatic push1(input int w);
    gq1.push_back(4'(1 << w));
    bq1.push_back({2'(w), d[w]});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (chk_zero) begin
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data",  32'(data),  32'd0);
      chk("rst_sel",   32'(sel),   32'd0);
      chk("rst_gnt",   32'(gnt),   32'd0);
    end
    if (chk_hold) begin
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_data",  32'(data),  32'(hold_val));
    end
    if (chk_idle) chk("idle_valid", 32'(valid), 32'd0);
    if (gnt != 4'd0) begin
      if (gq0.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
      else                 chk("gnt", 32'(gnt), 32'(gq0.pop_front()));
    end
    if (valid && ready) begin
      if (bq0.size() == 0) chk("beat_unexpected", 32'({sel, data}), 32'd0);
      else                 chk("beat", 32'({sel, data}), 32'(bq0.pop_front()));
    end
    if (gnt1 != 4'd0) begin
      if (gq1.size() == 0) chk("gnt1_unexpected", 32'(gnt1), 32'd0);
      else                 chk("gnt1", 32'(gnt1), 32'(gq1.pop_front()));
    end
    if (valid1 && ready1) begin
      if (bq1.size() == 0) chk("beat1_unexpected", 32'({sel1, data1}), 32'd0);
      else                 chk("beat1", 32'({sel1, data1}), 32'(bq1.pop_front()));
    end
    if (chk_end && !done) begin
      chk("left_gnt",   32'(gq0.size() + gq1.size()), 32'd0);
      chk("left_beats", 32'(bq0.size() + bq1.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; req = 4'd0; req1 = 4'd0; ready = 1'b1; ready1 = 1'b1;
    d[0] = 16'hA5A5; d[1] = 16'h5A5A; d[2] = 16'h3C3C; d[3] = 16'hC3C3;
    chk_zero = 1'b0; chk_hold = 1'b0; chk_idle = 1'b0; chk_end = 1'b0; done = 1'b0;
    hold_val = 16'h0;

    // Reset held with all requests up: nothing granted, outputs zero.
    cyc(2);
    req = 4'b1111;
    chk_zero = 1'b1;
    cyc(1);
    chk_zero = 1'b0;

    // Bursts of 4 per requester; MAX_BURST=1 instance rotates one beat each.
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) push0(r);
    for (int k = 0; k < 5; k++) push1(k % 4);
    req1 = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      if (c == 5) req1 = 4'b0000;
      cyc(1);
    end
    req = 4'b0000;
    cyc(1);

    // Lone requester 2: continuous grants, burst counter saturates.
    req = 4'b0100;
    for (int k = 0; k < 20; k++) push0(2);
    cyc(20);
    req = 4'b0000;
    cyc(1);

    // Backpressure: first accept goes to 0, output holds A5A5, then no-bubble resume.
    req = 4'b0101;
    push0(0);
    cyc(1);
    ready = 1'b0;
    hold_val = 16'hA5A5;
    chk_hold = 1'b1;
    cyc(3);
    chk_hold = 1'b0;
    ready = 1'b1;
    push0(0); push0(0); push0(0); push0(2);
    cyc(4);
    req = 4'b0000;
    cyc(1);
    chk_idle = 1'b1;
    cyc(1);
    chk_idle = 1'b0;

    // Drop mid-burst returns to IDLE; then 0011 after last=0 grants 1 first.
    req = 4'b0001;
    push0(0); push0(0);
    cyc(2);
    req = 4'b0000;
    cyc(1);
    req = 4'b0011;
    chk_idle = 1'b1;
    push0(1);
    cyc(1);
    chk_idle = 1'b0;
    req = 4'b0000;
    cyc(2);

    // Async reset mid-stream drops the held 1234 word; then 1000 grants 3.
    d[2] = 16'h1234;
    ready = 1'b0;
    req = 4'b0100;
    push0(2);
    cyc(1);
    req = 4'b0000;
    hold_val = 16'h1234;
    chk_hold = 1'b1;
    cyc(1);
    chk_hold = 1'b0;
    #2;
    rst_n = 1'b0;
    chk_zero = 1'b1;
    @(negedge clk);
    #1;
    chk_zero = 1'b0;
    bq0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    req = 4'b1000;
    push0(3);
    cyc(1);
    req = 4'b0000;
    cyc(2);

    chk_end = 1'b1;
    for (int k = 0; k < 10 && !done; k++) cyc(1);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL end_timeout actual=0 required=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
